theta_step_iter: RTL

Area-reduced, parametrised Keccak theta unit for Keccak-f[25·LANE_SIZE] permutations (LANE_SIZE = 1..64). It accumulates column parities over five cycles, one y-plane per cycle, instead of the single-cycle combinational XOR tree. It then applies the D deltas in a registered output stage. It sits between the round-state register and the rho/pi/chi/iota path. A valid/ready handshake on both sides lets the round controller stall it. A per-transaction bypass mode passes the state through unchanged for debug and round-skipping.

---
 rtl/theta_step_iter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/theta_step_iter.sv
// Keccak theta step with iterative column-parity accumulation.
// A transaction is accepted in IDLE. The five y-planes are folded into the
// column parities C[x], one plane per cycle. The D deltas are then applied in
// one registered cycle and the result is held until downstream accepts it.
// In bypass mode the captured state goes straight to the output register.
module theta_step_iter #(
    parameter int unsigned LANE_SIZE = 64,
    parameter int unsigned ROW_SIZE  = 5,
    parameter int unsigned COL_SIZE  = 5
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  in_state,
    input  logic                                              in_bypass,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  out_state,
    output logic                                              busy
);

    localparam int unsigned YCNT_W = 3;
    localparam logic [YCNT_W-1:0] Y_LAST = YCNT_W'(COL_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PARITY = 2'd1,
        ST_APPLY  = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] keccak_state_t;
    typedef logic [ROW_SIZE-1:0][LANE_SIZE-1:0]               plane_t;

    state_e        state_q, state_d;
    keccak_state_t s_q, s_d;
    keccak_state_t out_q, out_d;
    plane_t        c_q, c_d;
    logic [YCNT_W-1:0] y_cnt_q, y_cnt_d;
    logic          b_q, b_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;

    plane_t        d_c;
    keccak_state_t theta_c;

    // Rotate a lane left by one bit; degenerates to identity for one-bit lanes.
    function automatic logic [LANE_SIZE-1:0] rotl1(input logic [LANE_SIZE-1:0] v);
        return (v << 1) | (v >> (LANE_SIZE - 1));
    endfunction

    // Column deltas from the accumulated parities.
    for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_delta
        assign d_c[gx] = c_q[(gx + ROW_SIZE - 1) % ROW_SIZE]
                       ^ rotl1(c_q[(gx + 1) % ROW_SIZE]);
    end

    // Apply each column delta to every lane of that column.
    always_comb begin
        theta_c = '0;
        for (int x = 0; x < ROW_SIZE; x++) begin
            for (int y = 0; y < COL_SIZE; y++) begin
                theta_c[x][y] = s_q[x][y] ^ d_c[x];
            end
        end
    end

    // Next-state and datapath update for the accept/parity/apply/hold sequence.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        c_d     = c_q;
        y_cnt_d = y_cnt_q;
        out_d   = out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    s_d     = in_state;
                    b_d     = in_bypass;
                    c_d     = '0;
                    y_cnt_d = '0;
                    if (in_bypass) begin
                        out_d   = in_state;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                for (int x = 0; x < ROW_SIZE; x++) begin
                    c_d[x] = c_q[x] ^ s_q[x][y_cnt_q];
                end
                if (y_cnt_q == Y_LAST) begin
                    state_d = ST_APPLY;
                end else begin
                    y_cnt_d = y_cnt_q + YCNT_W'(1);
                end
            end
            ST_APPLY: begin
                out_d   = b_q ? s_q : theta_c;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            b_q         <= 1'b0;
            c_q         <= '0;
            y_cnt_q     <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            b_q         <= b_d;
            c_q         <= c_d;
            y_cnt_q     <= y_cnt_d;
            out_q       <= out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = out_q;

endmodule
